// File: rtl/cache_flush_sequencer_if.sv
// Handshake bundle between flush requesters, the flush sequencer and the
// cache subsystem. The sequencer takes the master modport.
interface cache_flush_sequencer_if #(
  parameter int unsigned NR_REQ = 2
);
  logic [NR_REQ-1:0] req_i;
  logic [NR_REQ-1:0] req_icache_i;
  logic [NR_REQ-1:0] ack_o;
  logic              error_o;
  logic              busy_o;
  logic              flush_dcache_o;
  logic              flush_dcache_ack_i;
  logic              flush_icache_o;

  modport master (
    input  req_i, req_icache_i, flush_dcache_ack_i,
    output ack_o, error_o, busy_o, flush_dcache_o, flush_icache_o
  );

  modport slave (
    output req_i, req_icache_i, flush_dcache_ack_i,
    input  ack_o, error_o, busy_o, flush_dcache_o, flush_icache_o
  );
endinterface

// File: rtl/cache_flush_sequencer.sv
// Round-robin serialiser of cache-maintenance requests onto one dcache/icache
// flush port. Optional dcache-ack timeout enabled by FLUSH_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | arbitrating; no sequence in flight
// DFLUSH | flush_dcache_o held, waiting for dcache ack
// IFLUSH | one-cycle icache flush pulse
// DONE   | ack_o pulse to granted requester, advance round-robin pointer
module cache_flush_sequencer #(
  parameter int unsigned NR_REQ        = 2,
  parameter int unsigned FLUSH_TIMEOUT = 1024
) (
  input logic                     clk_i,
  input logic                     rst_ni,
  cache_flush_sequencer_if.master bus
);

  localparam int unsigned IDX_W = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;

  if (NR_REQ < 1 || NR_REQ > 8 || FLUSH_TIMEOUT < 2) begin : g_bad_param
    $error("cache_flush_sequencer: illegal NR_REQ or FLUSH_TIMEOUT");
  end

  typedef enum logic [1:0] {IDLE, DFLUSH, IFLUSH, DONE} state_e;

  state_e            state_q;
  logic [IDX_W-1:0]  rr_q;
  logic [IDX_W-1:0]  grant_q;
  logic              icache_q;
  logic              mask_q;
  logic [NR_REQ-1:0] ack_q;
  logic              error_q;
  logic              busy_q;
  logic              flush_dcache_q;
  logic              flush_icache_q;

  logic [NR_REQ-1:0] req_eff;
  logic [IDX_W:0]    idx_sum;
  logic [IDX_W-1:0]  pick;
  logic              pick_vld;
  logic [IDX_W-1:0]  rr_next;
  logic [NR_REQ-1:0] grant_oh;
  logic              tmo_hit;

  assign bus.ack_o          = ack_q;
  assign bus.error_o        = error_q;
  assign bus.busy_o         = busy_q;
  assign bus.flush_dcache_o = flush_dcache_q;
  assign bus.flush_icache_o = flush_icache_q;

  assign grant_oh = NR_REQ'(1) << grant_q;
  assign rr_next  = (grant_q == IDX_W'(NR_REQ - 1)) ? '0 : grant_q + IDX_W'(1);

  // The first IDLE cycle after DONE hides the just-served requester, whose
  // request is still high while it reacts to ack_o.
  always_comb begin
    req_eff = bus.req_i;
    if (mask_q) req_eff[grant_q] = 1'b0;
  end

  always_comb begin
    pick_vld = 1'b0;
    pick     = '0;
    idx_sum  = '0;
    for (int i = 0; i < NR_REQ; i++) begin
      idx_sum = {1'b0, rr_q} + (IDX_W+1)'(i);
      if (idx_sum >= (IDX_W+1)'(NR_REQ)) idx_sum = idx_sum - (IDX_W+1)'(NR_REQ);
      if (!pick_vld && req_eff[idx_sum[IDX_W-1:0]]) begin
        pick_vld = 1'b1;
        pick     = idx_sum[IDX_W-1:0];
      end
    end
  end

`ifdef FLUSH_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(FLUSH_TIMEOUT);

  logic [TMO_W-1:0] tmo_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                tmo_q <= '0;
    else if (state_q != DFLUSH) tmo_q <= '0;
    else                        tmo_q <= tmo_q + TMO_W'(1);
  end

  assign tmo_hit = (state_q == DFLUSH) && (tmo_q == TMO_W'(FLUSH_TIMEOUT - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      rr_q           <= '0;
      grant_q        <= '0;
      icache_q       <= 1'b0;
      mask_q         <= 1'b0;
      ack_q          <= '0;
      error_q        <= 1'b0;
      busy_q         <= 1'b0;
      flush_dcache_q <= 1'b0;
      flush_icache_q <= 1'b0;
    end else begin
      ack_q          <= '0;
      error_q        <= 1'b0;
      flush_icache_q <= 1'b0;
      case (state_q)
        IDLE: begin
          mask_q <= 1'b0;
          if (pick_vld) begin
            grant_q        <= pick;
            icache_q       <= bus.req_icache_i[pick];
            state_q        <= DFLUSH;
            flush_dcache_q <= 1'b1;
            busy_q         <= 1'b1;
          end
        end
        DFLUSH: begin
          // A dcache ack in the timeout cycle takes the normal path.
          if (bus.flush_dcache_ack_i) begin
            flush_dcache_q <= 1'b0;
            if (icache_q) begin
              state_q        <= IFLUSH;
              flush_icache_q <= 1'b1;
            end else begin
              state_q <= DONE;
              ack_q   <= grant_oh;
            end
          end else if (tmo_hit) begin
            flush_dcache_q <= 1'b0;
            state_q        <= DONE;
            ack_q          <= grant_oh;
            error_q        <= 1'b1;
          end
        end
        IFLUSH: begin
          state_q <= DONE;
          ack_q   <= grant_oh;
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          mask_q  <= 1'b1;
          rr_q    <= rr_next;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_flush_sequencer.sv
// Directed bench for cache_flush_sequencer: cycle tables of inputs and
// expected outputs, plus hand-written reset-in-flight sequence.
module tb_cache_flush_sequencer;

  typedef struct {
    logic [1:0] req;
    logic [1:0] ic;
    logic       dack;
    logic [1:0] ack;
    logic       busy;
    logic       fd;
    logic       fi;
    logic       err;
  } vec_t;

  logic clk;
  logic rst_ni;
  int   n_cmp;
  int   n_err;
  vec_t vecs[$];

  cache_flush_sequencer_if #(.NR_REQ(2)) bus ();

  cache_flush_sequencer #(
    .NR_REQ       (2),
    .FLUSH_TIMEOUT(16)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_ni),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before 200us");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [1:0] req, input logic [1:0] ic, input logic dack,
                     input logic [1:0] ack, input logic busy, input logic fd,
                     input logic fi, input logic err);
    vec_t v;
    v.req = req; v.ic = ic; v.dack = dack;
    v.ack = ack; v.busy = busy; v.fd = fd; v.fi = fi; v.err = err;
    vecs.push_back(v);
  endtask

  task automatic check_outs(input string tag, input logic [1:0] ack, input logic busy,
                            input logic fd, input logic fi, input logic err);
    check({tag, " ack_o"},          32'(bus.ack_o),          32'(ack));
    check({tag, " busy_o"},         32'(bus.busy_o),         32'(busy));
    check({tag, " flush_dcache_o"}, 32'(bus.flush_dcache_o), 32'(fd));
    check({tag, " flush_icache_o"}, 32'(bus.flush_icache_o), 32'(fi));
    check({tag, " error_o"},        32'(bus.error_o),        32'(err));
  endtask

  // Each entry: inputs for one cycle and outputs expected in that same cycle.
  task automatic run_all(input string name);
    for (int i = 0; i < vecs.size(); i++) begin
      bus.req_i              = vecs[i].req;
      bus.req_icache_i       = vecs[i].ic;
      bus.flush_dcache_ack_i = vecs[i].dack;
      check_outs($sformatf("%s c%0d", name, i), vecs[i].ack, vecs[i].busy,
                 vecs[i].fd, vecs[i].fi, vecs[i].err);
      @(posedge clk);
      #1;
    end
    vecs.delete();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_ni = 1'b0;
    bus.req_i = '0;
    bus.req_icache_i = '0;
    bus.flush_dcache_ack_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_ni = 1'b1;

    // single request, dcache only, ack in cycle 5
    add(2'b01, 2'b00, 0, 2'b00, 0, 0, 0, 0);
    repeat (4) add(2'b01, 2'b00, 0, 2'b00, 1, 1, 0, 0);
    add(2'b01, 2'b00, 1, 2'b00, 1, 1, 0, 0);
    add(2'b01, 2'b00, 0, 2'b01, 1, 0, 0, 0);
    add(2'b00, 2'b00, 0, 2'b00, 0, 0, 0, 0);
    run_all("single");

    // requester 1 with icache, ack in cycle 3; icache flag drops after grant
    add(2'b10, 2'b10, 0, 2'b00, 0, 0, 0, 0);
    repeat (2) add(2'b10, 2'b10, 0, 2'b00, 1, 1, 0, 0);
    add(2'b10, 2'b10, 1, 2'b00, 1, 1, 0, 0);
    add(2'b10, 2'b00, 0, 2'b00, 1, 0, 1, 0);
    add(2'b10, 2'b00, 0, 2'b10, 1, 0, 0, 0);
    add(2'b00, 2'b00, 0, 2'b00, 0, 0, 0, 0);
    run_all("icache");

    // round-robin, both requesting, ack 2 cycles after each dcache flush rise
    for (int r = 0; r < 2; r++) begin
      add(2'b11, 2'b00, 0, 2'b00, 0, 0, 0, 0);
      repeat (2) add(2'b11, 2'b00, 0, 2'b00, 1, 1, 0, 0);
      add(2'b11, 2'b00, 1, 2'b00, 1, 1, 0, 0);
      add(2'b11, 2'b00, 0, 2'b01, 1, 0, 0, 0);
      add(2'b10, 2'b00, 0, 2'b00, 0, 0, 0, 0);
      repeat (2) add(2'b10, 2'b00, 0, 2'b00, 1, 1, 0, 0);
      add(2'b10, 2'b00, 1, 2'b00, 1, 1, 0, 0);
      add(2'b10, 2'b00, 0, 2'b10, 1, 0, 0, 0);
    end
    add(2'b00, 2'b00, 0, 2'b00, 0, 0, 0, 0);
    run_all("rr");

    // stray ack in IDLE, then a request that must wait for its own ack;
    // the request is held one extra cycle to check it is not re-granted
    add(2'b00, 2'b00, 1, 2'b00, 0, 0, 0, 0);
    add(2'b01, 2'b00, 0, 2'b00, 0, 0, 0, 0);
    repeat (2) add(2'b01, 2'b01, 0, 2'b00, 1, 1, 0, 0);
    add(2'b01, 2'b01, 1, 2'b00, 1, 1, 0, 0);
    add(2'b01, 2'b01, 0, 2'b01, 1, 0, 0, 0);
    add(2'b01, 2'b00, 0, 2'b00, 0, 0, 0, 0);
    add(2'b00, 2'b00, 0, 2'b00, 0, 0, 0, 0);
    add(2'b00, 2'b00, 0, 2'b00, 0, 0, 0, 0);
    run_all("stray");

    // reset while in DFLUSH (round-robin pointer is 1 at this point)
    bus.req_i = 2'b01;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_outs("pre_rst", 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
    rst_ni = 1'b0;
    #1;
    check_outs("async_rst", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.req_i = 2'b00;
    @(posedge clk); #1;
    check_outs("in_rst", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst_ni = 1'b1;

    // after release the pointer is back at 0, so requester 0 goes first
    add(2'b11, 2'b00, 0, 2'b00, 0, 0, 0, 0);
    add(2'b11, 2'b00, 0, 2'b00, 1, 1, 0, 0);
    add(2'b11, 2'b00, 1, 2'b00, 1, 1, 0, 0);
    add(2'b11, 2'b00, 0, 2'b01, 1, 0, 0, 0);
    add(2'b10, 2'b00, 0, 2'b00, 0, 0, 0, 0);
    add(2'b10, 2'b00, 0, 2'b00, 1, 1, 0, 0);
    add(2'b10, 2'b00, 1, 2'b00, 1, 1, 0, 0);
    add(2'b10, 2'b00, 0, 2'b10, 1, 0, 0, 0);
    add(2'b00, 2'b00, 0, 2'b00, 0, 0, 0, 0);
    run_all("post_rst");

`ifdef FLUSH_TIMEOUT_EN
    // no dcache ack: 16 cycles of flush, then ack and error together
    add(2'b01, 2'b01, 0, 2'b00, 0, 0, 0, 0);
    repeat (16) add(2'b01, 2'b01, 0, 2'b00, 1, 1, 0, 0);
    add(2'b01, 2'b01, 0, 2'b01, 1, 0, 0, 1);
    add(2'b00, 2'b00, 0, 2'b00, 0, 0, 0, 0);
    add(2'b00, 2'b00, 0, 2'b00, 0, 0, 0, 0);
    run_all("timeout");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cache_flush_sequencer.md
Name: cache_flush_sequencer

Overview:
- Serialises cache-maintenance requests from NR_REQ requesters (e.g. commit-stage fence/fence.i, debug module, CSR-triggered flush) onto the single dcache/icache flush interface.
- Per granted request, sequences: dcache flush with level handshake, then an optional one-cycle icache flush, then a completion pulse back to the requester.
- busy_o drives the pipeline halt while a sequence is in flight.
- Sits between the flush controller/commit logic and the cache subsystem.

Parameters:
- NR_REQ, 2, number of requesters; legal range 1..8.
- FLUSH_TIMEOUT, 1024, dcache-ack wait limit in cycles; used only with FLUSH_TIMEOUT_EN.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- req_i  in  NR_REQ  per-requester flush request; level, held until own ack_o.
- req_icache_i  in  NR_REQ  per-requester flag; also flush icache. Sampled at grant.
- ack_o  out  NR_REQ  one-cycle completion pulse to the granted requester.
- error_o  out  1  one-cycle pulse coincident with ack_o when the flush timed out.
- busy_o  out  1  sequence in flight; halt request to commit.
- flush_dcache_o  out  1  dcache flush request; held until acknowledged.
- flush_dcache_ack_i  in  1  dcache flush complete; single-cycle pulse.
- flush_icache_o  out  1  icache flush; one-cycle pulse.

Behaviour:
- Reset: state IDLE; rr_q=0; all outputs 0.
- Reset is legal in any state: the sequence is abandoned, no ack_o is issued, and the FSM resumes in IDLE after reset release.
- All outputs are Moore-decoded from registered state (no combinational input-to-output paths).
- FSM states: IDLE, DFLUSH, IFLUSH, DONE.
- IDLE:
  - If req_i!=0, round-robin select the lowest set index >= rr_q, wrapping to 0.
  - Latch grant_q=index and icache_q=req_icache_i[index]; go to DFLUSH.
  - flush_dcache_ack_i is ignored in IDLE.
- DFLUSH:
  - flush_dcache_o=1 and busy_o=1.
  - On flush_dcache_ack_i: go to IFLUSH if icache_q, else go to DONE.
- IFLUSH: flush_icache_o=1 and busy_o=1 for exactly one cycle, then DONE.
- DONE:
  - ack_o[grant_q]=1 and busy_o=1 for one cycle.
  - rr_q <= (grant_q+1) mod NR_REQ; go to IDLE.
- busy_o=0 only in IDLE.
- Latency (request raised in cycle 0, ack received in cycle k):
  - flush_dcache_o rises in cycle 1.
  - Without icache: ack_o in cycle k+1.
  - With icache: flush_icache_o in cycle k+1, ack_o in cycle k+2.
  - If ack arrives in cycle 1: minimum 3 cycles request-to-ack (no icache).
- Requester protocol:
  - Requester drops req_i in the cycle after it sees ack_o.
  - The IDLE cycle following DONE masks req_i[grant_q], so a held request is not re-granted back-to-back.
- Simultaneous requests: exactly one grant per sequence. Others wait with req_i held; no request is dropped.
- Requester deasserts req_i mid-sequence: the sequence completes and ack_o is still pulsed.
- req_icache_i changes after grant have no effect.
- Multiple flush_dcache_ack_i pulses in DFLUSH: only the first is used.
- rr_q wraps from NR_REQ-1 to 0.
- NR_REQ=1: rr_q is constant 0.

Optional Feature:
- Macro: FLUSH_TIMEOUT_EN.
- Defined:
  - A counter clears on DFLUSH entry and increments each DFLUSH cycle.
  - If it reaches FLUSH_TIMEOUT-1 without ack, go to DONE, skipping IFLUSH.
  - error_o=1 together with ack_o in DONE.
  - An ack in the same cycle as the timeout wins: the normal path is taken and error_o=0.
- Undefined: no counter; DFLUSH waits indefinitely; error_o tied 0.

Test Plan:
- Single request, no icache:
  - Stimulus: req_i=2'b01 in cycle 0; ack in cycle 5.
  - Required: flush_dcache_o=1 in cycles 1-5; ack_o=2'b01 in cycle 6; busy_o=1 in cycles 1-6, 0 in cycle 7.
- Single request with icache:
  - Stimulus: req_i=2'b10, req_icache_i=2'b10; ack in cycle 3.
  - Required: flush_icache_o=1 only in cycle 4; ack_o=2'b10 in cycle 5.
- Round-robin:
  - Stimulus: req_i=2'b11 held, each requester drops its req after its ack; dcache acks 2 cycles after each flush_dcache_o rise.
  - Required: grants 0 then 1; then req_i=2'b11 again grants 0 first (rr_q=0).
- Reset mid-flush:
  - Stimulus: assert rst_ni=0 in DFLUSH.
  - Required: all outputs 0 immediately; no ack_o; new request after release sequences normally.
- Stray ack in IDLE:
  - Stimulus: flush_dcache_ack_i pulse with req_i=0.
  - Required: no state change; next request still waits for its own ack.
- Timeout (FLUSH_TIMEOUT_EN, FLUSH_TIMEOUT=16):
  - Stimulus: no dcache ack, req_icache_i=1.
  - Required: flush_dcache_o high 16 cycles; flush_icache_o never pulses; ack_o and error_o both pulse in the following cycle.
